// File: rtl/decode_operand_stage_pkg.sv
// Shared types and constants for the decode operand stage: instruction word
// type and the bit positions of the source register fields.
package decode_operand_stage_pkg;

  localparam int INSTR_W        = 32'sd32;
  localparam int RS1_LSB        = 32'sd15;
  localparam int RS2_LSB        = 32'sd20;
  localparam int RS3_LSB        = 32'sd27;
  localparam int RS_W           = 32'sd5;
  localparam int MAX_READ_PORTS = 32'sd3;

  typedef logic [INSTR_W-1:0] instruction_type;

  // Low bit of the source-index field feeding read port `port`.
  function automatic int rs_lsb(input int port);
    case (port)
      32'sd0:  rs_lsb = RS1_LSB;
      32'sd1:  rs_lsb = RS2_LSB;
      default: rs_lsb = RS3_LSB;
    endcase
  endfunction

endpackage

// File: rtl/decode_operand_stage_if.sv
// Fetch-side, write-back and execute-side signals of the decode operand stage.
interface decode_operand_stage_if
  import decode_operand_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int RID_W          = 5,
  parameter int NUM_READ_PORTS = 2
);
  logic                           instr_valid;
  logic                           in_ready;
  instruction_type                instruction;
  logic [XLEN-1:0]                pc;
  logic                           compflg;
  logic                           write_en;
  logic [RID_W-1:0]               write_id;
  logic [XLEN-1:0]                write_data;
  logic                           flush;
  logic                           out_valid;
  logic                           out_ready;
  instruction_type                out_instruction;
  logic [XLEN-1:0]                out_pc;
  logic                           out_compflg;
  logic [NUM_READ_PORTS*XLEN-1:0] out_rs_data;

  modport master (
    output instr_valid, instruction, pc, compflg, write_en, write_id, write_data, flush, out_ready,
    input  in_ready, out_valid, out_instruction, out_pc, out_compflg, out_rs_data
  );

  modport slave (
    input  instr_valid, instruction, pc, compflg, write_en, write_id, write_data, flush, out_ready,
    output in_ready, out_valid, out_instruction, out_pc, out_compflg, out_rs_data
  );
endinterface

// File: rtl/decode_operand_stage_regfile.sv
// Register file for the decode stage: x0 hard-wired to zero, one write port,
// NUM_READ_PORTS combinational read ports with optional write-back forwarding.
module decode_regfile #(
  parameter  int XLEN           = 32,
  parameter  int NUM_REGS       = 32,
  parameter  int NUM_READ_PORTS = 2,
  parameter  int BYPASS         = 1,
  localparam int RID_W          = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_en,
  input  logic [RID_W-1:0] write_id,
  input  logic [XLEN-1:0]  write_data,
  input  logic [RID_W-1:0] rd_idx  [NUM_READ_PORTS],
  output logic [XLEN-1:0]  rd_data [NUM_READ_PORTS]
);

  localparam logic BYPASS_EN = (BYPASS != 32'sd0);

  logic [XLEN-1:0] regs_r [NUM_REGS];

  // Storage update; writes to x0 are dropped so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 32'sd0; i < NUM_REGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (write_en && (write_id != {RID_W{1'b0}})) begin
      regs_r[write_id] <= write_data;
    end
  end

  // Read muxes: zero for x0, forwarded write data when enabled, else storage.
  always_comb begin
    for (int p = 32'sd0; p < NUM_READ_PORTS; p++) begin
      rd_data[p] = {XLEN{1'b0}};
      if (rd_idx[p] == {RID_W{1'b0}}) begin
        rd_data[p] = {XLEN{1'b0}};
      end else if (BYPASS_EN && write_en && (write_id == rd_idx[p])) begin
        rd_data[p] = write_data;
      end else begin
        rd_data[p] = regs_r[rd_idx[p]];
      end
    end
  end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode front end: reads source operands for an incoming instruction and
// holds them in a one-entry valid/ready register that tracks later write-backs.
module decode_operand_stage
  import decode_operand_stage_pkg::*;
#(
  parameter  int XLEN           = 32,
  parameter  int NUM_REGS       = 32,
  parameter  int NUM_READ_PORTS = 2,
  parameter  int BYPASS         = 1,
  localparam int RID_W          = $clog2(NUM_REGS)
) (
  input logic                  clk,
  input logic                  rst_n,
  decode_operand_stage_if.slave bus
);

  if ((NUM_READ_PORTS < 32'sd1) || (NUM_READ_PORTS > MAX_READ_PORTS)) begin : g_bad_ports
    $error("decode_operand_stage: NUM_READ_PORTS must be 1..3");
  end
  if ((NUM_REGS < 32'sd2) || (NUM_REGS > 32'sd32) ||
      ((NUM_REGS & (NUM_REGS - 32'sd1)) != 32'sd0)) begin : g_bad_regs
    $error("decode_operand_stage: NUM_REGS must be a power of two in 2..32");
  end

  logic [RID_W-1:0]               rd_idx_s   [NUM_READ_PORTS];
  logic [RID_W-1:0]               held_idx_s [NUM_READ_PORTS];
  logic [XLEN-1:0]                rd_data_s  [NUM_READ_PORTS];
  logic                           in_ready_s;
  logic                           capture_s;
  logic                           out_valid_r, out_valid_nx_s;
  instruction_type                out_instr_r, out_instr_nx_s;
  logic [XLEN-1:0]                out_pc_r, out_pc_nx_s;
  logic                           out_compflg_r, out_compflg_nx_s;
  logic [NUM_READ_PORTS*XLEN-1:0] out_rs_r, out_rs_nx_s;

  // Source indices for the incoming and the held instruction.
  always_comb begin
    for (int p = 32'sd0; p < NUM_READ_PORTS; p++) begin
      rd_idx_s[p]   = bus.instruction[rs_lsb(p) +: RID_W];
      held_idx_s[p] = out_instr_r[rs_lsb(p) +: RID_W];
    end
  end

  decode_regfile #(
    .XLEN           (XLEN),
    .NUM_REGS       (NUM_REGS),
    .NUM_READ_PORTS (NUM_READ_PORTS),
    .BYPASS         (BYPASS)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (bus.write_en),
    .write_id   (bus.write_id),
    .write_data (bus.write_data),
    .rd_idx     (rd_idx_s),
    .rd_data    (rd_data_s)
  );

  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign capture_s  = bus.instr_valid && in_ready_s && !bus.flush;

  // Next state of the output register: flush > capture > drain; held
  // operands follow matching write-backs whenever nothing new is captured.
  always_comb begin
    out_valid_nx_s   = out_valid_r;
    out_instr_nx_s   = out_instr_r;
    out_pc_nx_s      = out_pc_r;
    out_compflg_nx_s = out_compflg_r;
    out_rs_nx_s      = out_rs_r;

    if (bus.flush) begin
      out_valid_nx_s = 1'b0;
    end else if (capture_s) begin
      out_valid_nx_s = 1'b1;
    end else if (bus.out_ready && out_valid_r) begin
      out_valid_nx_s = 1'b0;
    end else begin
      out_valid_nx_s = out_valid_r;
    end

    if (capture_s) begin
      out_instr_nx_s   = bus.instruction;
      out_pc_nx_s      = bus.pc;
      out_compflg_nx_s = bus.compflg;
      for (int p = 32'sd0; p < NUM_READ_PORTS; p++) begin
        out_rs_nx_s[p*XLEN +: XLEN] = rd_data_s[p];
      end
    end else begin
      for (int p = 32'sd0; p < NUM_READ_PORTS; p++) begin
        if (out_valid_r && bus.write_en && (held_idx_s[p] != {RID_W{1'b0}}) &&
            (held_idx_s[p] == bus.write_id)) begin
          out_rs_nx_s[p*XLEN +: XLEN] = bus.write_data;
        end else begin
          out_rs_nx_s[p*XLEN +: XLEN] = out_rs_r[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Output pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_instr_r   <= {INSTR_W{1'b0}};
      out_pc_r      <= {XLEN{1'b0}};
      out_compflg_r <= 1'b0;
      out_rs_r      <= {(NUM_READ_PORTS*XLEN){1'b0}};
    end else begin
      out_valid_r   <= out_valid_nx_s;
      out_instr_r   <= out_instr_nx_s;
      out_pc_r      <= out_pc_nx_s;
      out_compflg_r <= out_compflg_nx_s;
      out_rs_r      <= out_rs_nx_s;
    end
  end

  assign bus.in_ready        = in_ready_s;
  assign bus.out_valid       = out_valid_r;
  assign bus.out_instruction = out_instr_r;
  assign bus.out_pc          = out_pc_r;
  assign bus.out_compflg     = out_compflg_r;
  assign bus.out_rs_data     = out_rs_r;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench: a 3-port forwarding instance (ifa) and a 2-port
// non-forwarding instance (ifb) sharing clock and reset.
module tb_decode_operand_stage;
  import decode_operand_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  decode_operand_stage_if #(.XLEN(32), .RID_W(5), .NUM_READ_PORTS(3)) ifa ();
  decode_operand_stage_if #(.XLEN(32), .RID_W(5), .NUM_READ_PORTS(2)) ifb ();

  decode_operand_stage #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(3), .BYPASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  decode_operand_stage #(.XLEN(32), .NUM_REGS(32), .NUM_READ_PORTS(2), .BYPASS(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [4:0] rs3);
    logic [31:0] w;
    w = 32'h0000_0033;
    w[19:15] = rs1;
    w[24:20] = rs2;
    w[31:27] = rs3;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.instr_valid = 1'b0; ifa.instruction = 32'h0; ifa.pc = 32'h0; ifa.compflg = 1'b0;
    ifa.write_en = 1'b0; ifa.write_id = 5'd0; ifa.write_data = 32'h0; ifa.flush = 1'b0;
    ifa.out_ready = 1'b1;
    ifb.instr_valid = 1'b0; ifb.instruction = 32'h0; ifb.pc = 32'h0; ifb.compflg = 1'b0;
    ifb.write_en = 1'b0; ifb.write_id = 5'd0; ifb.write_data = 32'h0; ifb.flush = 1'b0;
    ifb.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL reset_valid got=%h exp=0", ifa.out_valid); else passed++;
    total++; if (ifa.out_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", ifa.out_pc); else passed++;
    total++; if (ifa.out_rs_data !== 96'h0) $display("FAIL reset_rs got=%h exp=0", ifa.out_rs_data); else passed++;
    total++; if (ifa.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%h exp=1", ifa.in_ready); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    ifa.write_en = 1'b1; ifa.write_id = 5'd5; ifa.write_data = 32'hDEAD_BEEF;
    tick();
    ifa.write_en = 1'b0;
    ifa.instr_valid = 1'b1; ifa.instruction = mk_instr(5'd5, 5'd0, 5'd0);
    ifa.pc = 32'h100; ifa.compflg = 1'b1; ifa.out_ready = 1'b1;
    tick();
    ifa.instr_valid = 1'b0;
    total++; if (ifa.out_valid !== 1'b1) $display("FAIL basic_valid got=%h exp=1", ifa.out_valid); else passed++;
    total++; if (ifa.out_rs_data[31:0] !== 32'hDEAD_BEEF) $display("FAIL basic_rs0 got=%h exp=deadbeef", ifa.out_rs_data[31:0]); else passed++;
    total++; if (ifa.out_rs_data[63:32] !== 32'h0) $display("FAIL basic_rs1 got=%h exp=0", ifa.out_rs_data[63:32]); else passed++;
    total++; if (ifa.out_pc !== 32'h100) $display("FAIL basic_pc got=%h exp=100", ifa.out_pc); else passed++;
    total++; if (ifa.out_compflg !== 1'b1) $display("FAIL basic_compflg got=%h exp=1", ifa.out_compflg); else passed++;
    total++; if (ifa.out_instruction !== mk_instr(5'd5, 5'd0, 5'd0)) $display("FAIL basic_instr got=%h exp=%h", ifa.out_instruction, mk_instr(5'd5, 5'd0, 5'd0)); else passed++;
    tick();
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL basic_drain got=%h exp=0", ifa.out_valid); else passed++;
  endtask

  task automatic test_bypass();
    ifa.write_en = 1'b1; ifa.write_id = 5'd7; ifa.write_data = 32'h1234;
    ifa.instr_valid = 1'b1; ifa.instruction = mk_instr(5'd7, 5'd0, 5'd0); ifa.pc = 32'h110;
    ifb.write_en = 1'b1; ifb.write_id = 5'd7; ifb.write_data = 32'h1234;
    ifb.instr_valid = 1'b1; ifb.instruction = mk_instr(5'd7, 5'd0, 5'd0); ifb.pc = 32'h110;
    tick();
    ifa.write_en = 1'b0; ifa.instr_valid = 1'b0;
    ifb.write_en = 1'b0;
    total++; if (ifa.out_rs_data[31:0] !== 32'h1234) $display("FAIL bypass_on got=%h exp=1234", ifa.out_rs_data[31:0]); else passed++;
    total++; if (ifb.out_rs_data[31:0] !== 32'h0) $display("FAIL bypass_off got=%h exp=0", ifb.out_rs_data[31:0]); else passed++;
    ifb.pc = 32'h114;
    tick();
    ifb.instr_valid = 1'b0;
    total++; if (ifb.out_rs_data[31:0] !== 32'h1234) $display("FAIL bypass_off_later got=%h exp=1234", ifb.out_rs_data[31:0]); else passed++;
    total++; if (ifb.out_pc !== 32'h114) $display("FAIL bypass_off_pc got=%h exp=114", ifb.out_pc); else passed++;
    tick();
    total++; if (ifb.out_valid !== 1'b0) $display("FAIL bypass_off_drain got=%h exp=0", ifb.out_valid); else passed++;
  endtask

  task automatic test_stall();
    ifa.write_en = 1'b1; ifa.write_id = 5'd9; ifa.write_data = 32'h1;
    tick();
    ifa.write_en = 1'b0;
    ifa.instr_valid = 1'b1; ifa.instruction = mk_instr(5'd0, 5'd9, 5'd0); ifa.pc = 32'h200;
    ifa.out_ready = 1'b0;
    tick();
    total++; if (ifa.out_rs_data[63:32] !== 32'h1) $display("FAIL stall_rs1_init got=%h exp=1", ifa.out_rs_data[63:32]); else passed++;
    ifa.instruction = mk_instr(5'd9, 5'd9, 5'd9); ifa.pc = 32'h300;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) begin
        ifa.write_en = 1'b1; ifa.write_id = 5'd9; ifa.write_data = 32'h55;
      end else begin
        ifa.write_en = 1'b0;
      end
      #1;
      total++; if (ifa.in_ready !== 1'b0) $display("FAIL stall_in_ready c%0d got=%h exp=0", c, ifa.in_ready); else passed++;
      tick();
      total++; if (ifa.out_pc !== 32'h200) $display("FAIL stall_pc c%0d got=%h exp=200", c, ifa.out_pc); else passed++;
      total++; if (ifa.out_valid !== 1'b1) $display("FAIL stall_valid c%0d got=%h exp=1", c, ifa.out_valid); else passed++;
    end
    ifa.write_en = 1'b0;
    total++; if (ifa.out_rs_data[63:32] !== 32'h55) $display("FAIL stall_refresh got=%h exp=55", ifa.out_rs_data[63:32]); else passed++;
    total++; if (ifa.out_rs_data[31:0] !== 32'h0) $display("FAIL stall_rs0 got=%h exp=0", ifa.out_rs_data[31:0]); else passed++;
  endtask

  task automatic test_flush();
    ifa.instr_valid = 1'b1; ifa.instruction = mk_instr(5'd3, 5'd0, 5'd0); ifa.pc = 32'h400;
    ifa.flush = 1'b1; ifa.write_en = 1'b1; ifa.write_id = 5'd3; ifa.write_data = 32'h33;
    tick();
    ifa.write_en = 1'b0; ifa.flush = 1'b0; ifa.instr_valid = 1'b0;
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL flush_valid got=%h exp=0", ifa.out_valid); else passed++;
    total++; if (ifa.out_pc !== 32'h200) $display("FAIL flush_no_capture got=%h exp=200", ifa.out_pc); else passed++;
    #1;
    total++; if (ifa.in_ready !== 1'b1) $display("FAIL flush_in_ready got=%h exp=1", ifa.in_ready); else passed++;
    ifa.out_ready = 1'b1;
    ifa.instr_valid = 1'b1; ifa.pc = 32'h500; ifa.flush = 1'b1;
    tick();
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL flush_idle_drop got=%h exp=0", ifa.out_valid); else passed++;
    ifa.flush = 1'b0; ifa.pc = 32'h600;
    tick();
    ifa.instr_valid = 1'b0;
    total++; if (ifa.out_rs_data[31:0] !== 32'h33) $display("FAIL flush_write_landed got=%h exp=33", ifa.out_rs_data[31:0]); else passed++;
    total++; if (ifa.out_pc !== 32'h600) $display("FAIL flush_next_pc got=%h exp=600", ifa.out_pc); else passed++;
    tick();
  endtask

  task automatic test_x0_and_port2();
    ifa.write_en = 1'b1; ifa.write_id = 5'd4; ifa.write_data = 32'hA5;
    tick();
    ifa.write_id = 5'd0; ifa.write_data = 32'hFFFF_FFFF;
    ifa.instr_valid = 1'b1; ifa.instruction = mk_instr(5'd0, 5'd4, 5'd4); ifa.pc = 32'h700;
    tick();
    ifa.write_en = 1'b0; ifa.instr_valid = 1'b0;
    total++; if (ifa.out_rs_data[31:0] !== 32'h0) $display("FAIL x0_read got=%h exp=0", ifa.out_rs_data[31:0]); else passed++;
    total++; if (ifa.out_rs_data[63:32] !== 32'hA5) $display("FAIL same_reg_p1 got=%h exp=a5", ifa.out_rs_data[63:32]); else passed++;
    total++; if (ifa.out_rs_data[95:64] !== 32'hA5) $display("FAIL port2_rs3 got=%h exp=a5", ifa.out_rs_data[95:64]); else passed++;
    tick();
    ifa.instr_valid = 1'b1; ifa.instruction = mk_instr(5'd0, 5'd0, 5'd0);
    tick();
    ifa.instr_valid = 1'b0;
    total++; if (ifa.out_rs_data[31:0] !== 32'h0) $display("FAIL x0_after_write got=%h exp=0", ifa.out_rs_data[31:0]); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    ifa.out_ready = 1'b1;
    ifa.instr_valid = 1'b1; ifa.instruction = mk_instr(5'd5, 5'd7, 5'd4);
    for (int k = 0; k < 4; k++) begin
      ifa.pc = 32'h1000 + 32'(k * 4);
      tick();
      total++; if (ifa.out_pc !== 32'h1000 + 32'(k * 4)) $display("FAIL b2b_pc k%0d got=%h exp=%h", k, ifa.out_pc, 32'h1000 + 32'(k * 4)); else passed++;
      total++; if (ifa.out_valid !== 1'b1) $display("FAIL b2b_valid k%0d got=%h exp=1", k, ifa.out_valid); else passed++;
    end
    total++; if (ifa.out_rs_data !== {32'hA5, 32'h1234, 32'hDEAD_BEEF}) $display("FAIL b2b_rs got=%h", ifa.out_rs_data); else passed++;
    ifa.instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    ifa.instr_valid = 1'b1; ifa.instruction = mk_instr(5'd5, 5'd9, 5'd4); ifa.pc = 32'h800;
    ifa.out_ready = 1'b0;
    tick();
    ifa.instr_valid = 1'b0;
    total++; if (ifa.out_valid !== 1'b1) $display("FAIL areset_pre_valid got=%h exp=1", ifa.out_valid); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL areset_valid got=%h exp=0", ifa.out_valid); else passed++;
    total++; if (ifa.out_pc !== 32'h0) $display("FAIL areset_pc got=%h exp=0", ifa.out_pc); else passed++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ifa.out_ready = 1'b1;
    ifa.instr_valid = 1'b1;
    tick();
    ifa.instr_valid = 1'b0;
    total++; if (ifa.out_valid !== 1'b1) $display("FAIL areset_post_valid got=%h exp=1", ifa.out_valid); else passed++;
    total++; if (ifa.out_rs_data !== 96'h0) $display("FAIL areset_regs_cleared got=%h exp=0", ifa.out_rs_data); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_stall();
    test_flush();
    test_x0_and_port2();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
